// File: rtl/lzc_seq.sv
// Iterative leading-zero counter: scans a WIDTH-bit operand MSB-first, one CHUNK per cycle.
// Optional macro LZC_SEQ_NORM_EN adds the intra-chunk shift so NormOut = Num << ZeroCnt.
module lzc_seq #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CHUNK = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         InValid,
   output logic                         InReady,
   input  logic [WIDTH-1:0]             Num,
   input  logic                         Flush,
   output logic                         OutValid,
   input  logic                         OutReady,
   output logic [$clog2(WIDTH+1)-1:0]   ZeroCnt,
   output logic                         AllZero,
   output logic [WIDTH-1:0]             NormOut
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned ZW     = $clog2(WIDTH + 1);
   localparam int unsigned CW     = $clog2(CHUNK + 1);
   localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e           r_state, w_state;
   logic [WIDTH-1:0] r_wr, w_wr;
   logic [ZW-1:0]    r_acc, w_acc;
   logic [IW-1:0]    r_idx, w_idx;

   logic [CHUNK-1:0] w_top;
   logic [CW-1:0]    w_cnt;
   logic             w_found;

   // Inner CHUNK-wide leading-zero counter on the top of the working register.
   always_comb begin
      w_top   = r_wr[WIDTH-1 -: CHUNK];
      w_cnt   = CW'(CHUNK);
      w_found = 1'b0;
      for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
         if (!w_found && w_top[i]) begin
            w_cnt   = CW'(int'(CHUNK) - 1 - i);
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_state = r_state;
      w_wr    = r_wr;
      w_acc   = r_acc;
      w_idx   = r_idx;
      if (Flush) begin
         w_state = StIdle;
      end else begin
         case (r_state)
            StIdle: begin
               if (InValid) begin
                  w_wr    = Num;
                  w_acc   = '0;
                  w_idx   = '0;
                  w_state = StScan;
               end
            end
            StScan: begin
               if (w_cnt != CW'(CHUNK)) begin
                  w_acc   = r_acc + ZW'(w_cnt);
`ifdef LZC_SEQ_NORM_EN
                  w_wr    = r_wr << w_cnt;
`else
                  w_wr    = r_wr;
`endif
                  w_state = StDone;
               end else begin
                  // Whole chunk is zero: skip it; the last chunk ends with Acc == WIDTH.
                  w_acc = r_acc + ZW'(CHUNK);
                  w_wr  = r_wr << CHUNK;
                  w_idx = r_idx + 1'b1;
                  if (r_idx == IW'(NCHUNK - 1)) begin
                     w_state = StDone;
                  end
               end
            end
            StDone: begin
               if (OutReady) begin
                  w_state = StIdle;
               end
            end
            default: w_state = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StIdle;
         r_wr    <= '0;
         r_acc   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state;
         r_wr    <= w_wr;
         r_acc   <= w_acc;
         r_idx   <= w_idx;
      end
   end

   assign InReady  = (r_state == StIdle);
   assign OutValid = (r_state == StDone);
   assign ZeroCnt  = OutValid ? r_acc : '0;
   assign AllZero  = OutValid && (r_acc == ZW'(WIDTH));
`ifdef LZC_SEQ_NORM_EN
   assign NormOut  = OutValid ? r_wr : '0;
`else
   assign NormOut  = '0;
`endif

endmodule

// File: tb/tb_lzc_seq.sv
// Bench for lzc_seq: directed cases plus random operands against a bit-scanning reference.
module tb_lzc_seq;

   localparam int unsigned WIDTH  = 64;
   localparam int unsigned CHUNK  = 16;
   localparam int unsigned NCHUNK = WIDTH / CHUNK;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              InValid, InReady, Flush, OutValid, OutReady, AllZero;
   logic [WIDTH-1:0]  Num, NormOut;
   logic [6:0]        ZeroCnt;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   lzc_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .InValid  (InValid),
      .InReady  (InReady),
      .Num      (Num),
      .Flush    (Flush),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .ZeroCnt  (ZeroCnt),
      .AllZero  (AllZero),
      .NormOut  (NormOut)
   );

   function automatic int ref_clz(input logic [WIDTH-1:0] n);
      int k = 0;
      while (k < int'(WIDTH) && n[WIDTH-1-k] == 1'b0) k++;
      return k;
   endfunction

   function automatic int ref_lat(input logic [WIDTH-1:0] n);
      if (n == '0) return int'(NCHUNK);
      return ref_clz(n) / int'(CHUNK) + 1;
   endfunction

   function automatic logic [WIDTH-1:0] ref_norm(input logic [WIDTH-1:0] n);
`ifdef LZC_SEQ_NORM_EN
      return n << ref_clz(n);
`else
      return '0;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one accept edge; InValid stays low afterwards.
   task automatic accept(input logic [WIDTH-1:0] n);
      int guard = 0;
      while (!InReady && guard < 20) begin
         tick();
         guard++;
      end
      check("in_ready_before_accept", 64'(InReady), 64'd1);
      InValid = 1'b1;
      Num     = n;
      tick();
      InValid = 1'b0;
      Num     = {$urandom, $urandom};
   endtask

   // Called just after the accepting edge; counts edges until OutValid and checks the result.
   task automatic await_result(input string tag, input logic [WIDTH-1:0] n);
      int edges = 0;
      while (!OutValid && edges < 20) begin
         tick();
         edges++;
      end
      check({tag, "_latency"}, 64'(edges), 64'(ref_lat(n)));
      check({tag, "_zerocnt"}, 64'(ZeroCnt), 64'(ref_clz(n)));
      check({tag, "_allzero"}, 64'(AllZero), 64'(n == '0));
      check({tag, "_normout"}, NormOut, ref_norm(n));
   endtask

   task automatic release_result(input string tag);
      OutReady = 1'b1;
      tick();
      OutReady = 1'b0;
      check({tag, "_outvalid_drop"}, 64'(OutValid), 64'd0);
      check({tag, "_inready_back"}, 64'(InReady), 64'd1);
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] n);
      accept(n);
      await_result(tag, n);
      release_result(tag);
   endtask

   initial begin
      logic [WIDTH-1:0] n;
      reset_n  = 1'b0;
      InValid  = 1'b0;
      OutReady = 1'b0;
      Flush    = 1'b0;
      Num      = '0;
      #12;
      check("reset_outvalid", 64'(OutValid), 64'd0);
      check("reset_zerocnt", 64'(ZeroCnt), 64'd0);
      check("reset_allzero", 64'(AllZero), 64'd0);
      check("reset_normout", NormOut, 64'd0);
      reset_n = 1'b1;
      tick();
      check("reset_inready", 64'(InReady), 64'd1);

      run_op("msb_set", 64'h8000_0000_0000_0000);
      run_op("bit16", 64'h0000_0000_0001_0000);
      run_op("all_zero", 64'h0);

      // Backpressure: result held while OutReady low; second operand waits.
      accept(64'h00F0_0000_0000_0000);
      await_result("bp_first", 64'h00F0_0000_0000_0000);
      InValid = 1'b1;
      Num     = 64'h1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_valid", 64'(OutValid), 64'd1);
         check("bp_hold_cnt", 64'(ZeroCnt), 64'd8);
         check("bp_hold_inready", 64'(InReady), 64'd0);
      end
      OutReady = 1'b1;
      tick();
      OutReady = 1'b0;
      check("bp_no_same_cycle_accept", 64'(InReady), 64'd1);
      check("bp_outvalid_drop", 64'(OutValid), 64'd0);
      tick();
      InValid = 1'b0;
      await_result("bp_second", 64'h1);
      release_result("bp_second");

      // Flush in the second SCAN cycle.
      accept(64'h1);
      tick();
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      check("flush_idle", 64'(InReady), 64'd1);
      for (int i = 0; i < 4; i++) begin
         check("flush_no_result", 64'(OutValid), 64'd0);
         tick();
      end
      // Flush in IDLE beats InValid.
      Flush   = 1'b1;
      InValid = 1'b1;
      Num     = 64'h5;
      tick();
      Flush   = 1'b0;
      InValid = 1'b0;
      check("flush_blocks_accept", 64'(InReady), 64'd1);
      run_op("after_flush", 64'h0000_8000_0000_0000);

      // Asynchronous reset mid-SCAN, between edges.
      accept(64'h1);
      tick();
      #2 reset_n = 1'b0;
      #1;
      check("areset_outvalid", 64'(OutValid), 64'd0);
      check("areset_zerocnt", 64'(ZeroCnt), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("areset_inready", 64'(InReady), 64'd1);
      run_op("after_reset", 64'h1);

      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 4) == 0) n = '0;
         else n = {$urandom, $urandom} >> $urandom_range(0, 63);
         run_op("random", n);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
